// File: rtl/pipeline_trace_unit_pkg.sv
// Shared types for the pipeline trace unit: capture states, instruction
// field positions, instruction-type encodings and the stored entry layout.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } trace_state_t;

  localparam int COND_HI = 31;
  localparam int COND_LO = 30;
  localparam int TIPO_HI = 29;
  localparam int TIPO_LO = 28;
  localparam int OPC_HI  = 27;
  localparam int OPC_LO  = 25;
  localparam int RD_HI   = 24;
  localparam int RD_LO   = 21;
  localparam int RN_HI   = 20;
  localparam int RN_LO   = 17;

  localparam logic [1:0] TIPO_REG  = 2'd0;
  localparam logic [1:0] TIPO_IMM  = 2'd1;
  localparam logic [1:0] TIPO_MEM  = 2'd2;
  localparam logic [1:0] TIPO_CTRL = 2'd3;

  // Default-width entry; the top rebuilds this shape from its own parameters.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [15:0] ts;
  } trace_entry_t;

endpackage

// File: rtl/pipeline_trace_unit_if.sv
// Retire tap and readout port of the trace unit.
interface pipeline_trace_unit_if #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int TS_W = 16
);
  logic            tr_valid_i;
  logic [AW-1:0]   tr_pc_i;
  logic [31:0]     tr_instr_i;
  logic [DW-1:0]   tr_result_i;
  logic [3:0]      tr_flags_i;

  logic            rd_valid_o;
  logic            rd_ready_i;
  logic [AW-1:0]   rd_pc_o;
  logic [31:0]     rd_instr_o;
  logic [DW-1:0]   rd_result_o;
  logic [3:0]      rd_flags_o;
  logic [TS_W-1:0] rd_ts_o;

  modport master (
    output tr_valid_i, tr_pc_i, tr_instr_i, tr_result_i, tr_flags_i, rd_ready_i,
    input  rd_valid_o, rd_pc_o, rd_instr_o, rd_result_o, rd_flags_o, rd_ts_o
  );

  modport slave (
    input  tr_valid_i, tr_pc_i, tr_instr_i, tr_result_i, tr_flags_i, rd_ready_i,
    output rd_valid_o, rd_pc_o, rd_instr_o, rd_result_o, rd_flags_o, rd_ts_o
  );
endinterface

// File: rtl/pipeline_trace_unit_ram.sv
// Trace history storage: one synchronous write port, one combinational read
// port, contents deliberately not reset.
module trace_ram
  import trace_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = trace_entry_t
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  entry_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output entry_t                   rdata
);
  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/pipeline_trace_unit.sv
// Retire-stream trace buffer: pre-trigger circular capture, field trigger,
// post-trigger count, oldest-first drain and per-type retire counters.
module pipeline_trace_unit
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int TS_W  = 16,
  parameter int TC_W  = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm_i,
  input  logic [6:0]            trig_mask_i,
  input  logic [6:0]            trig_match_i,
  input  logic [CNT_W-1:0]      post_count_i,
  pipeline_trace_unit_if.slave  bus,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      level_o,
  output logic                  trig_seen_o,
  output logic [4*TC_W-1:0]     type_count_o
);
  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] MAX_POST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);

  typedef struct packed {
    logic [AW-1:0]   pc;
    logic [31:0]     instr;
    logic [DW-1:0]   result;
    logic [3:0]      flags;
    logic [TS_W-1:0] ts;
  } entry_t;

  trace_state_t     state_reg, state_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] level_reg, level_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic             trig_seen_reg, trig_seen_next;
  logic [TS_W-1:0]  ts_reg;

  logic             record, tc_clear, trig_hit, rd_valid, pop;
  logic [CNT_W-1:0] post_eff;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       rec_tipo;
  entry_t           wr_entry, rd_entry;

  assign trig_hit = ((bus.tr_instr_i[COND_HI:OPC_LO] ^ trig_match_i) & trig_mask_i) == 7'd0;
  // Clamp so the trigger entry itself can never be overwritten by post-trigger records.
  assign post_eff = (post_count_i > MAX_POST) ? MAX_POST : post_count_i;
  assign rd_valid = (state_reg == FROZEN) && (level_reg != '0);
  assign pop      = rd_valid && bus.rd_ready_i;
  assign rd_ptr   = wr_ptr_reg - level_reg[PTR_W-1:0];
  assign rec_tipo = bus.tr_instr_i[TIPO_HI:TIPO_LO];

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    level_next     = level_reg;
    remaining_next = remaining_reg;
    trig_seen_next = trig_seen_reg;
    record         = 1'b0;
    tc_clear       = 1'b0;
    if (arm_i) begin
      state_next     = ARMED;
      wr_ptr_next    = '0;
      level_next     = '0;
      remaining_next = '0;
      trig_seen_next = 1'b0;
      tc_clear       = 1'b1;
    end else begin
      case (state_reg)
        ARMED: if (bus.tr_valid_i) begin
          record = 1'b1;
          if (trig_hit) begin
            trig_seen_next = 1'b1;
            if (post_eff == '0) begin
              state_next = FROZEN;
            end else begin
              state_next     = POST;
              remaining_next = post_eff;
            end
          end
        end
        POST: if (bus.tr_valid_i) begin
          record         = 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == CNT_W'(1)) state_next = FROZEN;
        end
        FROZEN: if (pop) begin
          level_next = level_reg - 1'b1;
          if (level_reg == CNT_W'(1)) state_next = IDLE;
        end
        default: ;
      endcase
      if (record) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
        if (level_reg != FULL) level_next = level_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      level_reg     <= '0;
      remaining_reg <= '0;
      trig_seen_reg <= 1'b0;
      ts_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      level_reg     <= level_next;
      remaining_reg <= remaining_next;
      trig_seen_reg <= trig_seen_next;
      ts_reg        <= ts_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : gen_tc
    logic [TC_W-1:0] count_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        count_reg <= '0;
      end else if (tc_clear) begin
        count_reg <= '0;
      end else if (record && rec_tipo == 2'(gi) && count_reg != '1) begin
        count_reg <= count_reg + 1'b1;
      end
    end
    assign type_count_o[gi*TC_W +: TC_W] = count_reg;
  end

  assign wr_entry = '{pc: bus.tr_pc_i, instr: bus.tr_instr_i, result: bus.tr_result_i,
                      flags: bus.tr_flags_i, ts: ts_reg};

  trace_ram #(.DEPTH(DEPTH), .entry_t(entry_t)) u_ram (
    .clk   (clk),
    .we    (record),
    .waddr (wr_ptr_reg),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign bus.rd_valid_o  = rd_valid;
  assign bus.rd_pc_o     = rd_valid ? rd_entry.pc     : '0;
  assign bus.rd_instr_o  = rd_valid ? rd_entry.instr  : '0;
  assign bus.rd_result_o = rd_valid ? rd_entry.result : '0;
  assign bus.rd_flags_o  = rd_valid ? rd_entry.flags  : '0;
  assign bus.rd_ts_o     = rd_valid ? rd_entry.ts     : '0;

  assign state_o     = state_reg;
  assign level_o     = level_reg;
  assign trig_seen_o = trig_seen_reg;
endmodule

// File: tb/tb_pipeline_trace_unit.sv
// Directed bench for pipeline_trace_unit with a readout scoreboard; a second
// instance with 2-bit type counters covers counter saturation.
module tb_pipeline_trace_unit;
  import trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             arm, arm2;
  logic [6:0]       mask, match, mask2, match2;
  logic [CNT_W-1:0] post, post2;
  logic [1:0]       state, state2;
  logic [CNT_W-1:0] level, level2;
  logic             seen, seen2;
  logic [63:0]      tcount;
  logic [7:0]       tcount2;

  pipeline_trace_unit_if #(.AW(32), .DW(32), .TS_W(16)) m ();
  pipeline_trace_unit_if #(.AW(32), .DW(32), .TS_W(16)) s ();

  pipeline_trace_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .arm_i(arm), .trig_mask_i(mask), .trig_match_i(match),
    .post_count_i(post), .bus(m), .state_o(state), .level_o(level),
    .trig_seen_o(seen), .type_count_o(tcount)
  );

  pipeline_trace_unit #(.DEPTH(DEPTH), .TC_W(2)) dut_tc (
    .clk(clk), .rst(rst), .arm_i(arm2), .trig_mask_i(mask2), .trig_match_i(match2),
    .post_count_i(post2), .bus(s), .state_o(state2), .level_o(level2),
    .trig_seen_o(seen2), .type_count_o(tcount2)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [15:0] ts;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] tb_ts;
  logic [31:0] last_pc, last_instr;

  // Free-running reference timestamp, used to predict each entry's ts field.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_ts <= '0;
    else      tb_ts <= tb_ts + 16'd1;
  end

  always @(negedge clk) begin
    if (m.rd_valid_o && m.rd_ready_i) begin
      exp_t got, want;
      got = '{pc: m.rd_pc_o, instr: m.rd_instr_o, result: m.rd_result_o,
              flags: m.rd_flags_o, ts: m.rd_ts_o};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got pc=%08h instr=%08h, required no entry", got.pc, got.instr);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL pop: got pc=%08h instr=%08h res=%08h fl=%h ts=%04h, required pc=%08h instr=%08h res=%08h fl=%h ts=%04h",
                   got.pc, got.instr, got.result, got.flags, got.ts,
                   want.pc, want.instr, want.result, want.flags, want.ts);
        end else begin
          $display("[TB] pop pc=%08h instr=%08h ts=%04h", got.pc, got.instr, got.ts);
        end
      end
      last_pc    = got.pc;
      last_instr = got.instr;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [1:0] tipo, input logic [2:0] opc, input int k);
    return {2'b00, tipo, opc, 25'(k)};
  endfunction

  task automatic retire(input int k, input logic [31:0] instr, input bit keep);
    exp_t e;
    m.tr_valid_i  = 1'b1;
    m.tr_pc_i     = 32'(4 * k);
    m.tr_instr_i  = instr;
    m.tr_result_i = 32'hA000_0000 + 32'(k);
    m.tr_flags_i  = 4'(k);
    if (keep) begin
      e = '{pc: 32'(4 * k), instr: instr, result: 32'hA000_0000 + 32'(k),
            flags: 4'(k), ts: tb_ts};
      exp_q.push_back(e);
      if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
    end
    $display("[TB] retire pc=%08h instr=%08h", m.tr_pc_i, instr);
    step();
    m.tr_valid_i = 1'b0;
  endtask

  task automatic retire2(input logic [1:0] tipo, input int k);
    s.tr_valid_i = 1'b1;
    s.tr_pc_i    = 32'(4 * k);
    s.tr_instr_i = mk(tipo, 3'b010, k);
    $display("[TB] retire2 pc=%08h tipo=%0d", s.tr_pc_i, tipo);
    step();
    s.tr_valid_i = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  logic [31:0] br, held_pc;

  initial begin
    arm = 0; mask = 0; match = 0; post = 0;
    arm2 = 0; mask2 = 7'h7F; match2 = 7'h7F; post2 = 0;
    m.tr_valid_i = 0; m.tr_pc_i = 0; m.tr_instr_i = 0; m.tr_result_i = 0; m.tr_flags_i = 0;
    m.rd_ready_i = 0;
    s.tr_valid_i = 0; s.tr_pc_i = 0; s.tr_instr_i = 0; s.tr_result_i = 0; s.tr_flags_i = 0;
    s.rd_ready_i = 0;
    last_pc = 0; last_instr = 0;

    step(); step();
    chk("reset_state", 64'(state), 64'(IDLE));
    chk("reset_level", 64'(level), 64'd0);
    chk("reset_rd_valid", 64'(m.rd_valid_o), 64'd0);
    chk("reset_rd_pc", 64'(m.rd_pc_o), 64'd0);
    chk("reset_trig_seen", 64'(seen), 64'd0);
    chk("reset_type_count", tcount, 64'd0);
    rst = 1'b1;
    step();

    // Test 1: trigger that never matches keeps capturing in ARMED
    mask = 7'h7F; match = 7'h7F;
    do_arm();
    for (int k = 0; k < 3; k++) retire(k, mk(TIPO_REG, 3'b000, k), 1'b0);
    chk("t1_state", 64'(state), 64'(ARMED));
    chk("t1_level", 64'(level), 64'd3);
    chk("t1_rd_valid", 64'(m.rd_valid_o), 64'd0);

    // Test 2: branch trigger with two post-trigger records, buffer wrapped
    br = mk(TIPO_CTRL, 3'b000, 0);
    match = 7'b00_11_000; post = 5'd2;
    do_arm();
    for (int k = 0; k < 20; k++) retire(k, mk(2'(k % 3), 3'b001, k), 1'b1);
    retire(20, br, 1'b1);
    chk("t2_state_post", 64'(state), 64'(POST));
    retire(21, mk(TIPO_REG, 3'b001, 21), 1'b1);
    retire(22, mk(TIPO_IMM, 3'b001, 22), 1'b1);
    chk("t2_state_frozen", 64'(state), 64'(FROZEN));
    chk("t2_level", 64'(level), 64'd16);
    chk("t2_trig_seen", 64'(seen), 64'd1);
    chk("t2_first_pc", 64'(m.rd_pc_o), 64'h1C);
    chk("t2_type_count", tcount, {16'd1, 16'd6, 16'd8, 16'd8});

    // Test 3: backpressure then full drain
    held_pc = m.rd_pc_o;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_hold_pc", 64'(m.rd_pc_o), 64'(held_pc));
      chk("t3_hold_level", 64'(level), 64'd16);
    end
    m.rd_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) step();
    m.rd_ready_i = 1'b0;
    chk("t3_state_idle", 64'(state), 64'(IDLE));
    chk("t3_rd_valid", 64'(m.rd_valid_o), 64'd0);
    chk("t3_rd_pc_zero", 64'(m.rd_pc_o), 64'd0);
    chk("t3_last_pc", 64'(last_pc), 64'h58);
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // Test 4: zero post count, trigger on the fifth retire
    post = 5'd0;
    br = mk(TIPO_CTRL, 3'b000, 4);
    do_arm();
    for (int k = 0; k < 4; k++) retire(k, mk(TIPO_MEM, 3'b010, k), 1'b1);
    retire(4, br, 1'b1);
    chk("t4_state", 64'(state), 64'(FROZEN));
    chk("t4_level", 64'(level), 64'd5);
    m.rd_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    m.rd_ready_i = 1'b0;
    chk("t4_last_instr", 64'(last_instr), 64'(br));
    chk("t4_state_idle", 64'(state), 64'(IDLE));

    // Test 5: arm wins over a same-cycle retire during POST
    post = 5'd5;
    do_arm();
    retire(0, mk(TIPO_CTRL, 3'b000, 0), 1'b0);
    chk("t5_state_post", 64'(state), 64'(POST));
    arm = 1'b1;
    m.tr_valid_i = 1'b1;
    m.tr_instr_i = mk(TIPO_REG, 3'b001, 1);
    step();
    arm = 1'b0;
    m.tr_valid_i = 1'b0;
    chk("t5_state", 64'(state), 64'(ARMED));
    chk("t5_level", 64'(level), 64'd0);
    chk("t5_trig_seen", 64'(seen), 64'd0);
    chk("t5_type_count", tcount, 64'd0);

    // Test 6: 2-bit type counters saturate
    arm2 = 1'b1;
    step();
    arm2 = 1'b0;
    retire2(TIPO_REG, 0);
    retire2(TIPO_REG, 1);
    retire2(TIPO_IMM, 2);
    for (int k = 3; k < 8; k++) retire2(TIPO_MEM, k);
    chk("t6_level", 64'(level2), 64'd8);
    chk("t6_type_count", 64'(tcount2), 64'({2'd0, 2'd3, 2'd1, 2'd2}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_trace_unit.md
Name: pipeline_trace_unit

Overview:
Synthesisable on-chip trace buffer for the 5-stage pipeline. It replaces display-only monitoring with captured hardware history. It taps the writeback-side retire stream (PC, instruction, result, NZCV flags) and records it into a parametrised circular buffer. Capture supports a pre-trigger window, a programmable instruction-field trigger and a post-trigger count. The frozen history drains oldest-first over a valid/ready port, and the block keeps per-instruction-type retire counters.

Parameters:
DEPTH, 16, buffer entries; power of 2, at least 4.
AW, 32, PC width.
DW, 32, result width.
TS_W, 16, timestamp counter width.
TC_W, 16, width of each type counter.
CNT_W, $clog2(DEPTH)+1, level and post-count width (derived).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-low reset.
arm_i  in  1  clear and start capture; highest priority.
trig_mask_i  in  7  per-bit compare enable over instr[31:25] {cond,tipo,opcode}.
trig_match_i  in  7  compare value over instr[31:25].
post_count_i  in  CNT_W  entries to record after the trigger; sampled at trigger.
tr_valid_i  in  1  retire strobe.
tr_pc_i  in  AW  retired PC.
tr_instr_i  in  32  retired instruction.
tr_result_i  in  DW  writeback result.
tr_flags_i  in  4  NZCV.
rd_valid_o  out  1  readout entry available.
rd_ready_i  in  1  readout accept.
rd_pc_o, rd_instr_o, rd_result_o, rd_flags_o, rd_ts_o  out  AW/32/DW/4/TS_W  oldest entry.
state_o  out  2  IDLE=0, ARMED=1, POST=2, FROZEN=3.
level_o  out  CNT_W  valid entries held.
trig_seen_o  out  1  trigger has fired since last arm.
type_count_o  out  4*TC_W  recorded retires per tipo; slice k holds tipo k (REG, IMM, MEM, CTRL).

Behaviour:
- Reset (rst low, async): state IDLE, wr_ptr=0, level=0, remaining=0, trig_seen=0, type counts=0, timestamp=0, rd_valid_o=0. All rd_* data outputs are 0 at reset; the buffer array is not reset.
- rd_* data outputs are forced to 0 whenever rd_valid_o=0.
- Timestamp: free-running, +1 every cycle, wraps mod 2^TS_W. Each entry stores the timestamp value of its write cycle.
- A "record" writes {pc, instr, result, flags, ts} at wr_ptr, then wr_ptr=(wr_ptr+1) mod DEPTH and level=min(level+1, DEPTH). When the buffer is full, the oldest entry is overwritten. A record also increments type count[instr[29:28]], saturating at all-ones.
- arm_i=1 in any state: next state ARMED; wr_ptr, level, remaining, trig_seen and type counts clear. A tr_valid_i in the same cycle is NOT recorded.
- IDLE: tr_valid_i is ignored.
- ARMED: every tr_valid_i records.
  - Trigger: tr_valid_i && ((tr_instr_i[31:25] ^ trig_match_i) & trig_mask_i) == 0. A mask of 0 triggers on the first retire.
  - On the trigger cycle the trigger entry is recorded and trig_seen=1.
  - The effective post count is P = min(post_count_i, DEPTH-1), so the trigger entry is always retained.
  - P=0 gives FROZEN next cycle; otherwise POST with remaining=P.
- POST: each tr_valid_i records and decrements remaining; when remaining reaches 0 the next state is FROZEN. Triggers are not re-evaluated.
- FROZEN: tr_valid_i is ignored.
  - rd_valid_o = (level != 0). Data comes from slot rd_ptr = (wr_ptr - level) mod DEPTH, via combinational read.
  - Handshake: a pop occurs when rd_valid_o && rd_ready_i, and level decrements. The next entry is presented in the following cycle.
  - While rd_valid_o && !rd_ready_i, all rd_* outputs hold stable.
  - When the final pop brings level to 0, the next state is IDLE; rd_valid_o is low in IDLE.
- Reset asserted mid-capture or mid-readout: immediate return to reset values; the captured history is lost.
- Latency: a record is visible in level_o the cycle after tr_valid_i.

Decomposition:
- Package trace_pkg holds:
  - the state enum;
  - instruction field slice constants (COND 31:30, TIPO 29:28, OPC 27:25, RD 24:21, RN 20:17);
  - tipo encodings REG/IMM/MEM/CTRL;
  - the packed trace_entry_t struct.
- Sub-module trace_ram: DEPTH x trace_entry_t storage, one synchronous write port and one asynchronous read port, no reset.

Test Plan:
1. Reset, arm, mask=0x7F, match=0x7F (never matches), 3 retires: state=ARMED, level=3, rd_valid_o=0.
2. DEPTH=16, arm, match on {cond=00,tipo=11,op=000} (B), mask=0x7F, post_count=2. Drive 20 non-branch retires with pc=4k, then B at k=20, then k=21 and 22.
   - Result: FROZEN, level=16.
   - First rd_pc_o=0x1C, last popped pc=0x58.
3. Backpressure in FROZEN: rd_ready_i low for 3 cycles, then high for 16 cycles.
   - While low: rd_pc_o stable, level=16.
   - While high: one pop per cycle, then state=IDLE and rd_valid_o=0.
4. post_count_i=0, trigger on the 5th retire: FROZEN the next cycle, level=5, fifth popped rd_instr_o equals the trigger instruction.
5. In POST, assert arm_i together with tr_valid_i: next state=ARMED, level=0, trig_seen_o=0, type counts=0.
6. TC_W=2, arm, then 2 REG, 1 IMM and 5 MEM retires: type_count_o slices are REG=2, IMM=1, MEM=3 (saturated), CTRL=0.
